// File: rtl/sequencer_pkg.sv
// Shared definitions for the instruction-cycle sequencer and its branch evaluator.
package sequencer_pkg;

    // Externally visible STATE encoding; the halted state reports as UPDATE.
    localparam logic [1:0] STATE_FETCH   = 2'd0;
    localparam logic [1:0] STATE_DECODE  = 2'd1;
    localparam logic [1:0] STATE_EXECUTE = 2'd2;
    localparam logic [1:0] STATE_UPDATE  = 2'd3;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_UPDATE,
        S_HALTED
    } seq_state_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_NOP,
        CLS_BR,
        CLS_JMP,
        CLS_HALT
    } op_class_e;

    localparam logic [4:0] OP_NOP  = 5'h00;
    localparam logic [4:0] OP_BR   = 5'h13;
    localparam logic [4:0] OP_JMP  = 5'h14;
    localparam logic [4:0] OP_HALT = 5'h1F;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_LT = 4'h2;
    localparam logic [3:0] CC_GE = 4'h3;
    localparam logic [3:0] CC_GT = 4'h4;
    localparam logic [3:0] CC_LE = 4'h5;
    localparam logic [3:0] CC_CS = 4'h6;
    localparam logic [3:0] CC_CC = 4'h7;
    localparam logic [3:0] CC_MI = 4'h8;
    localparam logic [3:0] CC_PL = 4'h9;
    localparam logic [3:0] CC_VS = 4'hA;
    localparam logic [3:0] CC_VC = 4'hB;

    localparam int unsigned FLAG_Z  = 3;
    localparam int unsigned FLAG_N  = 2;
    localparam int unsigned FLAG_C  = 1;
    localparam int unsigned FLAG_OV = 0;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluator: (flags, condition code) -> taken.
module branch_cond_eval
    import sequencer_pkg::*;
#(
    parameter int unsigned COND_W = 4
) (
    input  logic [3:0]        flags_i,
    input  logic [COND_W-1:0] cond_i,
    output logic              taken_o
);

    // Decode the condition code against the flag word; codes C..F never branch.
    always_comb begin
        logic lt;
        lt      = flags_i[FLAG_N] ^ flags_i[FLAG_OV];
        taken_o = 1'b0;
        case (cond_i)
            COND_W'(CC_EQ): taken_o = flags_i[FLAG_Z];
            COND_W'(CC_NE): taken_o = !flags_i[FLAG_Z];
            COND_W'(CC_LT): taken_o = lt;
            COND_W'(CC_GE): taken_o = !lt;
            COND_W'(CC_GT): taken_o = !flags_i[FLAG_Z] && !lt;
            COND_W'(CC_LE): taken_o = flags_i[FLAG_Z] || lt;
            COND_W'(CC_CS): taken_o = flags_i[FLAG_C];
            COND_W'(CC_CC): taken_o = !flags_i[FLAG_C];
            COND_W'(CC_MI): taken_o = flags_i[FLAG_N];
            COND_W'(CC_PL): taken_o = !flags_i[FLAG_N];
            COND_W'(CC_VS): taken_o = flags_i[FLAG_OV];
            COND_W'(CC_VC): taken_o = !flags_i[FLAG_OV];
            default:        taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// Instruction-cycle sequencer (FETCH/DECODE/EXECUTE/UPDATE) with ALU flag register
// and program-counter control strobes, all changing on the rising clock edge.
module branch_sequencer
    import sequencer_pkg::*;
#(
    parameter int unsigned OPCODE_W = 5,
    parameter int unsigned COND_W   = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                RUN,
    input  logic [OPCODE_W-1:0] OPCODE,
    input  logic [COND_W-1:0]   COND,
    input  logic [3:0]          FLAGS_IN,
    input  logic                FLAGS_WE,
    output logic                IR_LOAD,
    output logic                WPC,
    output logic                ALU,
    output logic                UC,
    output logic [3:0]          FLAGS,
    output logic [1:0]          STATE,
    output logic                HALTED
);

    seq_state_e state_q;
    op_class_e  cls_q;
    logic [3:0] flags_q;
    logic       wpc_q;
    logic       alu_q;
    logic       uc_q;
    logic       halted_q;
    logic       taken;

    function automatic op_class_e classify(input logic [OPCODE_W-1:0] op);
        if (op == OPCODE_W'(OP_BR))   return CLS_BR;
        if (op == OPCODE_W'(OP_JMP))  return CLS_JMP;
        if (op == OPCODE_W'(OP_HALT)) return CLS_HALT;
        if (op == OPCODE_W'(OP_NOP))  return CLS_NOP;
        return CLS_ALU;
    endfunction

    branch_cond_eval #(
        .COND_W (COND_W)
    ) u_cond (
        .flags_i (flags_q),
        .cond_i  (COND),
        .taken_o (taken)
    );

    // Sequencer FSM, flag register and registered UPDATE strobes.
    // Strobes are loaded on the EXECUTE->UPDATE edge so they are high for
    // exactly the UPDATE cycle; BR never writes flags, so taken is final here.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_FETCH;
            cls_q    <= CLS_NOP;
            flags_q  <= '0;
            wpc_q    <= 1'b0;
            alu_q    <= 1'b0;
            uc_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (RUN) state_q <= S_DECODE;
                end
                S_DECODE: begin
                    cls_q   <= classify(OPCODE);
                    state_q <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (FLAGS_WE && cls_q == CLS_ALU) flags_q <= FLAGS_IN;
                    wpc_q   <= (cls_q != CLS_HALT);
                    alu_q   <= (cls_q == CLS_BR) && taken;
                    uc_q    <= (cls_q == CLS_JMP);
                    state_q <= S_UPDATE;
                end
                S_UPDATE: begin
                    wpc_q <= 1'b0;
                    alu_q <= 1'b0;
                    uc_q  <= 1'b0;
                    if (cls_q == CLS_HALT) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALTED;
                    end else begin
                        state_q  <= S_FETCH;
                    end
                end
                S_HALTED: begin
                    state_q <= S_HALTED;
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    // Report the internal state on the 2-bit STATE port.
    always_comb begin
        STATE = STATE_FETCH;
        case (state_q)
            S_FETCH:   STATE = STATE_FETCH;
            S_DECODE:  STATE = STATE_DECODE;
            S_EXECUTE: STATE = STATE_EXECUTE;
            S_UPDATE:  STATE = STATE_UPDATE;
            S_HALTED:  STATE = STATE_UPDATE;
            default:   STATE = STATE_FETCH;
        endcase
    end

    // IR load follows RUN in FETCH and is forced low while reset is held.
    assign IR_LOAD = (state_q == S_FETCH) && RUN && !RESET;
    assign WPC     = wpc_q;
    assign ALU     = alu_q;
    assign UC      = uc_q;
    assign FLAGS   = flags_q;
    assign HALTED  = halted_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed scenarios plus randomized
// instruction streams compared every cycle against an instruction-level model.
module tb_branch_sequencer;

    logic       CLK;
    logic       RESET;
    logic       RUN;
    logic [4:0] OPCODE;
    logic [3:0] COND;
    logic [3:0] FLAGS_IN;
    logic       FLAGS_WE;
    logic       IR_LOAD;
    logic       WPC;
    logic       ALU;
    logic       UC;
    logic [3:0] FLAGS;
    logic [1:0] STATE;
    logic       HALTED;

    int n_cmp;
    int n_err;

    // Reference model: position within the instruction, halt status, flag word.
    int         m_phase;
    bit         m_halted;
    logic [3:0] m_flags;

    // Strobes observed in the most recent UPDATE cycle.
    logic upd_wpc;
    logic upd_alu;
    logic upd_uc;

    branch_sequencer #(
        .OPCODE_W (5),
        .COND_W   (4)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .RUN      (RUN),
        .OPCODE   (OPCODE),
        .COND     (COND),
        .FLAGS_IN (FLAGS_IN),
        .FLAGS_WE (FLAGS_WE),
        .IR_LOAD  (IR_LOAD),
        .WPC      (WPC),
        .ALU      (ALU),
        .UC       (UC),
        .FLAGS    (FLAGS),
        .STATE    (STATE),
        .HALTED   (HALTED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_taken(input logic [3:0] f, input logic [3:0] c);
        bit z, n, cy, v, lt;
        z = f[3]; n = f[2]; cy = f[1]; v = f[0];
        lt = n ^ v;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return lt;
            4'h3: return !lt;
            4'h4: return !z && !lt;
            4'h5: return z || lt;
            4'h6: return cy;
            4'h7: return !cy;
            4'h8: return n;
            4'h9: return !n;
            4'hA: return v;
            4'hB: return !v;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit is_alu_class(input logic [4:0] op);
        return !(op == 5'h00 || op == 5'h13 || op == 5'h14 || op == 5'h1F);
    endfunction

    task automatic model_reset();
        m_phase  = 0;
        m_halted = 1'b0;
        m_flags  = 4'h0;
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_step();
        if (RESET) begin
            model_reset();
        end else if (!m_halted) begin
            case (m_phase)
                0: if (RUN) m_phase = 1;
                1: m_phase = 2;
                2: begin
                    if (is_alu_class(OPCODE) && FLAGS_WE) m_flags = FLAGS_IN;
                    m_phase = 3;
                end
                default: begin
                    if (OPCODE == 5'h1F) m_halted = 1'b1;
                    else m_phase = 0;
                end
            endcase
        end
    endtask

    task automatic check_all();
        bit in_upd;
        in_upd = !m_halted && m_phase == 3 && !RESET;
        expect_eq("STATE",   32'(STATE),   m_halted ? 32'd3 : 32'(m_phase));
        expect_eq("HALTED",  32'(HALTED),  32'(m_halted));
        expect_eq("FLAGS",   32'(FLAGS),   32'(m_flags));
        expect_eq("IR_LOAD", 32'(IR_LOAD), 32'(!m_halted && m_phase == 0 && RUN && !RESET));
        expect_eq("WPC",     32'(WPC),     32'(in_upd && OPCODE != 5'h1F));
        expect_eq("ALU",     32'(ALU),     32'(in_upd && OPCODE == 5'h13 && ref_taken(m_flags, COND)));
        expect_eq("UC",      32'(UC),      32'(in_upd && OPCODE == 5'h14));
    endtask

    // One clock: check outputs mid-cycle, then step the model at the rising edge.
    task automatic cycle();
        @(negedge CLK);
        #1;
        check_all();
        if (!m_halted && m_phase == 3) begin
            upd_wpc = WPC;
            upd_alu = ALU;
            upd_uc  = UC;
        end
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        model_reset();
        #1;
        check_all();
        cycle();
        cycle();
        RESET = 1'b0;
    endtask

    // Issue one instruction: a few idle FETCH cycles with RUN low, then RUN high
    // until the model reports completion; RUN is randomized after leaving FETCH.
    task automatic run_instr(input logic [4:0] op, input logic [3:0] cc,
                             input logic [3:0] fin, input logic fwe);
        bit done;
        int idle;
        OPCODE   = op;
        COND     = cc;
        FLAGS_IN = fin;
        FLAGS_WE = fwe;
        idle = $urandom_range(0, 2);
        for (int i = 0; i < idle; i++) begin
            RUN = 1'b0;
            cycle();
        end
        RUN  = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            cycle();
            if (m_phase == 0 || m_halted) done = 1'b1;
            else RUN = 1'($urandom_range(0, 1));
        end
        expect_eq("instr_done", 32'(done), 32'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        upd_wpc = 1'b0;
        upd_alu = 1'b0;
        upd_uc  = 1'b0;
        RUN      = 1'b0;
        OPCODE   = 5'h00;
        COND     = 4'h0;
        FLAGS_IN = 4'h0;
        FLAGS_WE = 1'b0;
        RESET    = 1'b1;
        model_reset();
        #2;
        check_all();
        @(posedge CLK);
        #1;
        apply_reset();

        // NOP stream: one WPC pulse per instruction, no jump requests.
        for (int i = 0; i < 3; i++) begin
            run_instr(5'h00, 4'h0, 4'hF, 1'b1);
            expect_eq("nop_wpc", 32'(upd_wpc), 32'd1);
            expect_eq("nop_alu_uc", 32'({upd_alu, upd_uc}), 32'd0);
        end
        expect_eq("nop_flags", 32'(FLAGS), 32'h0);

        // JMP: unconditional request in UPDATE, cleared in the next FETCH.
        run_instr(5'h14, 4'h0, 4'h0, 1'b0);
        expect_eq("jmp_uc", 32'(upd_uc), 32'd1);
        expect_eq("jmp_wpc", 32'(upd_wpc), 32'd1);
        expect_eq("jmp_alu", 32'(upd_alu), 32'd0);
        expect_eq("jmp_after_uc", 32'(UC), 32'd0);
        expect_eq("jmp_after_wpc", 32'(WPC), 32'd0);

        // ALU op loads Z, following BR sees it immediately.
        run_instr(5'h02, 4'h0, 4'b1000, 1'b1);
        run_instr(5'h13, 4'h0, 4'h0, 1'b0);
        expect_eq("br_eq_flags", 32'(FLAGS), 32'h8);
        expect_eq("br_eq_taken", 32'(upd_alu), 32'd1);
        run_instr(5'h02, 4'h0, 4'b1000, 1'b1);
        run_instr(5'h13, 4'h1, 4'h0, 1'b0);
        expect_eq("br_ne_taken", 32'(upd_alu), 32'd0);
        expect_eq("br_ne_wpc", 32'(upd_wpc), 32'd1);

        // Signed compare with N=1, OV=0; reserved code; BR ignores FLAGS_WE.
        run_instr(5'h02, 4'h0, 4'b0100, 1'b1);
        run_instr(5'h13, 4'h2, 4'h0, 1'b0);
        expect_eq("br_lt", 32'(upd_alu), 32'd1);
        run_instr(5'h13, 4'h3, 4'h0, 1'b0);
        expect_eq("br_ge", 32'(upd_alu), 32'd0);
        run_instr(5'h13, 4'hC, 4'h0, 1'b0);
        expect_eq("br_reserved", 32'(upd_alu), 32'd0);
        run_instr(5'h13, 4'h0, 4'h0, 1'b1);
        expect_eq("br_keeps_flags", 32'(FLAGS), 32'h4);

        // HALT: no WPC, sticky halted state, only reset exits.
        run_instr(5'h1F, 4'h0, 4'h0, 1'b0);
        expect_eq("halt_wpc", 32'(upd_wpc), 32'd0);
        expect_eq("halt_flag", 32'(HALTED), 32'd1);
        for (int i = 0; i < 20; i++) begin
            RUN      = 1'($urandom_range(0, 1));
            OPCODE   = 5'($urandom_range(0, 31));
            FLAGS_WE = 1'($urandom_range(0, 1));
            FLAGS_IN = 4'($urandom_range(0, 15));
            cycle();
        end
        apply_reset();
        expect_eq("halt_reset_state", 32'(STATE), 32'd0);
        expect_eq("halt_reset_halted", 32'(HALTED), 32'd0);

        // Asynchronous reset during EXECUTE of an instruction following a flag load.
        run_instr(5'h02, 4'h0, 4'b1010, 1'b1);
        OPCODE   = 5'h05;
        FLAGS_IN = 4'b0110;
        FLAGS_WE = 1'b1;
        RUN      = 1'b1;
        for (int k = 0; k < 4 && m_phase != 2; k++) cycle();
        expect_eq("pre_reset_state", 32'(STATE), 32'd2);
        #2;
        RESET = 1'b1;
        model_reset();
        #1;
        expect_eq("async_state", 32'(STATE), 32'd0);
        expect_eq("async_flags", 32'(FLAGS), 32'd0);
        expect_eq("async_wpc", 32'(WPC), 32'd0);
        @(posedge CLK);
        model_step();
        #1;
        for (int i = 0; i < 2; i++) cycle();
        RESET = 1'b0;

        // Randomized instruction stream.
        for (int n = 0; n < 200; n++) begin
            int r;
            logic [4:0] op;
            r = $urandom_range(0, 19);
            if (r == 0)      op = 5'h1F;
            else if (r < 5)  op = 5'h13;
            else if (r < 8)  op = 5'h14;
            else if (r < 10) op = 5'h00;
            else begin
                op = 5'($urandom_range(1, 30));
                while (op == 5'h13 || op == 5'h14) op = 5'($urandom_range(1, 30));
            end
            run_instr(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)));
            if (m_halted) begin
                for (int i = 0; i < 5; i++) begin
                    RUN = 1'($urandom_range(0, 1));
                    cycle();
                end
                apply_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Instruction-cycle sequencer and branch-condition unit sitting directly upstream of the program counter. It steps each instruction through FETCH/DECODE/EXECUTE/UPDATE and holds the ALU status flags. In UPDATE it drives the counter's write strobe (WPC), conditional-jump request (ALU) and unconditional-jump request (UC). All state changes on posedge CLK, so the counter, which samples on negedge, always sees stable controls.

## Interface
- OPCODE_W, default 5: opcode field width.
- COND_W, default 4: condition-code field width.
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  reset, asynchronous, active-high.
- RUN  in  1  level enable; sequencer leaves FETCH only while high.
- OPCODE  in  OPCODE_W  opcode of the current instruction, stable from DECODE through UPDATE.
- COND  in  COND_W  branch condition code, same stability window.
- FLAGS_IN  in  4  ALU status {Z,N,C,OV} (bit3..bit0).
- FLAGS_WE  in  1  ALU request to update flags.
- IR_LOAD  out  1  instruction-register load strobe, high in FETCH when RUN=1.
- WPC  out  1  program-counter write strobe.
- ALU  out  1  conditional branch taken.
- UC  out  1  unconditional jump.
- FLAGS  out  4  latched flag register.
- STATE  out  2  current state: FETCH=0, DECODE=1, EXECUTE=2, UPDATE=3.
- HALTED  out  1  sequencer stopped.

## Operation
- Reset values: STATE=FETCH, FLAGS=0, HALTED=0, IR_LOAD=WPC=ALU=UC=0.
- FETCH: if RUN=1, assert IR_LOAD and go to DECODE. Otherwise hold with IR_LOAD=0.
- DECODE: classify OPCODE and go to EXECUTE.
  - 5'h13 BR (conditional).
  - 5'h14 JMP.
  - 5'h1F HALT.
  - 5'h00 NOP.
  - All other values are ALU class.
- EXECUTE: FLAGS <= FLAGS_IN only if FLAGS_WE=1 and class is ALU. FLAGS_WE is ignored for BR, JMP, HALT and NOP. Go to UPDATE.
- UPDATE outputs:
  - BR: WPC=1, ALU=cond(FLAGS,COND), UC=0.
  - JMP: WPC=1, UC=1, ALU=0.
  - ALU class and NOP: WPC=1, ALU=UC=0.
  - HALT: WPC=ALU=UC=0.
  - All except HALT then return to FETCH. HALT goes to the HALTED state instead.
- cond() definitions, using LT = N^OV:
  - 0 EQ = Z; 1 NE = !Z.
  - 2 LT; 3 GE = !LT.
  - 4 GT = !Z & !LT; 5 LE = Z | LT.
  - 6 CS = C; 7 CC = !C.
  - 8 MI = N; 9 PL = !N.
  - A VS = OV; B VC = !OV.
  - C–F never taken (0).
- HALTED (internal fifth state, reported as STATE=3):
  - HALTED output=1 and all strobes 0.
  - RUN, OPCODE and FLAGS_WE are ignored.
  - Only RESET exits.
- ALU and UC are 0 in every state except UPDATE, and are never both 1.

## Timing
- Instruction latency is 4 CLK cycles with RUN held high. WPC is high for exactly one full cycle per instruction.
- The counter samples at the negedge inside UPDATE and needs 0 extra cycles. Its new address is valid before the next FETCH.
- RUN deasserted mid-instruction does not stall DECODE, EXECUTE or UPDATE; it only gates leaving FETCH.
- Flags written by an ALU instruction are visible to a BR immediately following it: EXECUTE of the ALU op precedes UPDATE of the BR.
- RESET mid-operation: all outputs go to reset values immediately (asynchronous) and no WPC pulse is emitted. The first FETCH follows the first posedge after release with RUN=1.

## Structure
- Shared package (sequencer_pkg):
  - State encoding constants.
  - Opcode constants OP_NOP/OP_BR/OP_JMP/OP_HALT.
  - Condition-code constants 0–B.
  - Flag bit indices Z=3, N=2, C=1, OV=0.
- One natural sub-module: branch_cond_eval, a combinational evaluator (FLAGS, COND) -> taken. It is reused by the flag-display logic.
- The FSM and flag register stay in branch_sequencer.

## Test plan
- Reset, RUN=1, OPCODE=5'h00 -> STATE cycles 0,1,2,3. WPC=1 only when STATE=3, once every 4 cycles. ALU=UC=0 throughout.
- OPCODE=5'h14 -> in UPDATE WPC=1, UC=1, ALU=0. Both back to 0 in the following FETCH.
- ALU op 5'h02 with FLAGS_IN=4'b1000 and FLAGS_WE=1, then BR:
  - COND=0 -> FLAGS=4'b1000, ALU=1.
  - Repeat with COND=1 -> ALU=0, WPC=1.
- FLAGS=4'b0100 (N=1, OV=0):
  - COND=2 -> ALU=1.
  - COND=3 -> 0.
  - COND=4'hC -> 0.
  - BR with FLAGS_WE=1 and FLAGS_IN=0 -> FLAGS unchanged.
- OPCODE=5'h1F -> UPDATE has WPC=0 and HALTED=1 next cycle. 20 cycles of RUN toggling -> no WPC/IR_LOAD. RESET -> HALTED=0, STATE=0.
- RESET asserted mid-EXECUTE after FLAGS load -> same-cycle STATE=0, FLAGS=0, no WPC pulse before release.
